twentynm_fpll_dps_ctrl: RTL and testbench
=========================================

// Module: twentynm_fpll_dps_ctrl
// PURPOSE
// - Dynamic phase-shift (DPS) sequencer for the fPLL C-counters; sits between core logic and the fPLL DPS pins.
// - Accepts one request per handshake: counter index, direction and step count (arbitrarily wide).
// - Splits each request into bursts of at most 7 steps to fit the fPLL 3-bit num_phase_shifts field.
// - Drives cnt_sel/num_phase_shifts/up_dn/phase_en per burst and waits for phase_done; adds timeout and lock-loss abort.
// PARAMETERS
// - NUM_COUNTERS     4     number of valid C-counters, 1..16; req_cnt >= NUM_COUNTERS is rejected
// - STEP_W           16    width of req_steps
// - PHASE_EN_CYCLES  2     phase_en high time per burst, cycles, >=1
// - TIMEOUT_CYCLES   1024  max cycles waiting for phase_done per burst, >=2
// PORTS
// - avmmclk          in   1       single clock; all logic rising-edge
// - avmmrst          in   1       synchronous active-high reset
// - req_valid        in   1       request valid
// - req_ready        out  1       request accepted on edge where req_valid & req_ready
// - req_cnt          in   4       target C-counter index
// - req_steps        in   STEP_W  number of phase steps; 0 allowed
// - req_up           in   1       1 = shift up, 0 = shift down
// - busy             out  1       request in progress
// - done             out  1       1-cycle pulse: request finished (success or error)
// - err_badcnt       out  1       sticky until next accept: index out of range
// - err_timeout      out  1       sticky until next accept: phase_done not seen in time
// - err_unlock       out  1       sticky until next accept: lock dropped mid-request
// - steps_left       out  STEP_W  remaining steps of current request
// - cnt_sel          out  4       to fPLL
// - num_phase_shifts out  3       to fPLL
// - up_dn            out  1       to fPLL
// - phase_en         out  1       to fPLL
// - phase_done       in   1       from fPLL; high level = burst complete
// - lock             in   1       from fPLL lock output
// BEHAVIOUR
// - Reset (sync, highest priority): state IDLE; all outputs 0 except req_ready = lock; mid-burst phase_en drops at next edge.
// - req_ready = (state==IDLE) & lock; errors are cleared and steps_left loaded with req_steps on accept.
// - FSM: IDLE -> CHECK -> SETUP -> PULSE -> WAIT -> NEXT -> (SETUP | FIN) -> IDLE; busy = state != IDLE.
// - CHECK: req_cnt >= NUM_COUNTERS -> set err_badcnt, go FIN; req_steps==0 -> FIN. Neither case asserts phase_en.
// - SETUP (1 cycle): burst = min(steps_left,7); drive cnt_sel, num_phase_shifts = burst, and up_dn; phase_en = 0.
// - PULSE: phase_en = 1 for exactly PHASE_EN_CYCLES cycles; cnt_sel, num_phase_shifts and up_dn stay stable.
// - WAIT: phase_en = 0; the timeout counter starts at 0. phase_done=1 -> NEXT. Counter reaching TIMEOUT_CYCLES-1 -> set err_timeout, go FIN.
// - NEXT: steps_left -= burst (no underflow possible); if steps_left is now 0 -> FIN, else -> SETUP.
// - FIN: done = 1 for 1 cycle; DPS outputs -> 0; next state IDLE.
// - Lock loss: lock=0 in SETUP/PULSE/WAIT/NEXT -> set err_unlock, go FIN. phase_en drops the same edge; steps_left freezes.
// - Simultaneous events in WAIT: phase_done=1 and timeout together -> phase_done wins. Lock loss beats both.
// - Latency, steps<=7, phase_done returned d cycles after phase_en falls:
//   done is high in cycle 4+PHASE_EN_CYCLES+d after the accept edge.
// CONFIGURATION
// - FPLL_DPS_ACCUM_EN defined: adds output phase_accum [NUM_COUNTERS*(STEP_W+1)-1:0].
//   It holds one signed accumulator per counter.
//   In NEXT the selected accumulator gets +burst (up) or -burst (down); it wraps two's-complement.
//   Accumulators are cleared by reset only.
// - FPLL_DPS_ACCUM_EN undefined: no port and no accumulator logic; all other behaviour identical.
// TESTING
// - cnt=2, steps=5, up=1, phase_done 3 cycles after pulse
//   -> one burst: cnt_sel=2, num=5, up_dn=1, phase_en 2 cycles; done in cycle 9; no errors.
// - cnt=1, steps=20, up=0 -> bursts num=7,7,6; steps_left 20->13->6->0; done once; accum[1] = -20 with _EN.
// - cnt=5 with NUM_COUNTERS=4 -> err_badcnt=1, done pulse, phase_en never high, steps_left=20 unchanged.
// - phase_done held 0, TIMEOUT_CYCLES=16 -> err_timeout set in WAIT cycle 16; done; req_ready back next cycle.
// - lock drops during 2nd burst of steps=20 -> phase_en 0 next edge; err_unlock=1; steps_left=13; req_ready stays 0 until lock.
// - avmmrst during PULSE -> next cycle all outputs 0; a new request with steps=3 then completes normally.

Source files
------------

// File: rtl/twentynm_fpll_dps_ctrl.sv
// fPLL dynamic phase-shift sequencer: splits step requests into <=7-step bursts on the DPS pins.
// Optional FPLL_DPS_ACCUM_EN adds per-counter signed phase accumulators (phase_accum).
module twentynm_fpll_dps_ctrl #(
    parameter int NUM_COUNTERS    = 4,
    parameter int STEP_W          = 16,
    parameter int PHASE_EN_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
`ifdef FPLL_DPS_ACCUM_EN
    output logic [NUM_COUNTERS*(STEP_W+1)-1:0] phase_accum,
`endif
    input  logic              avmmclk,
    input  logic              avmmrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cnt,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              req_up,
    output logic              busy,
    output logic              done,
    output logic              err_badcnt,
    output logic              err_timeout,
    output logic              err_unlock,
    output logic [STEP_W-1:0] steps_left,
    output logic [3:0]        cnt_sel,
    output logic [2:0]        num_phase_shifts,
    output logic              up_dn,
    output logic              phase_en,
    input  logic              phase_done,
    input  logic              lock
);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > PHASE_EN_CYCLES) ? TIMEOUT_CYCLES : PHASE_EN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int AW      = STEP_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SETUP, S_PULSE, S_WAIT, S_NEXT, S_FIN} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt_r;
    logic              up_r;
    logic [TMR_W-1:0]  tmr;
    logic [2:0]        burst;
    logic [STEP_W-1:0] steps_dec;
    logic              accept, active;
    logic              set_badcnt, set_timeout, set_unlock;

    assign accept    = req_valid & req_ready;
    assign burst     = (steps_left > STEP_W'(7)) ? 3'd7 : steps_left[2:0];
    assign steps_dec = steps_left - STEP_W'(burst);
    assign active    = state inside {S_SETUP, S_PULSE, S_WAIT, S_NEXT};

    // DPS pins decode straight from registered state, so any move to FIN/IDLE drops them on that edge
    assign req_ready        = (state == S_IDLE) & lock;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_FIN);
    assign phase_en         = (state == S_PULSE);
    assign cnt_sel          = active ? cnt_r : 4'd0;
    assign num_phase_shifts = active ? burst : 3'd0;
    assign up_dn            = active & up_r;

    always_comb begin
        state_nxt   = state;
        set_badcnt  = 1'b0;
        set_timeout = 1'b0;
        set_unlock  = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CHECK;
            S_CHECK: begin
                if ({1'b0, cnt_r} >= 5'(NUM_COUNTERS)) begin
                    set_badcnt = 1'b1;
                    state_nxt  = S_FIN;
                end else if (steps_left == '0) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!lock) begin
                    set_unlock = 1'b1;
                    state_nxt  = S_FIN;
                end else begin
                    state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (!lock) begin
                    set_unlock = 1'b1;
                    state_nxt  = S_FIN;
                end else if (tmr == TMR_W'(PHASE_EN_CYCLES - 1)) begin
                    state_nxt = S_WAIT;
                end
            end
            // lock loss outranks phase_done, which outranks the timeout
            S_WAIT: begin
                if (!lock) begin
                    set_unlock = 1'b1;
                    state_nxt  = S_FIN;
                end else if (phase_done) begin
                    state_nxt = S_NEXT;
                end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_FIN;
                end
            end
            S_NEXT: begin
                if (!lock) begin
                    set_unlock = 1'b1;
                    state_nxt  = S_FIN;
                end else if (steps_dec == '0) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_SETUP;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge avmmclk) begin
        if (avmmrst) begin
            state       <= S_IDLE;
            tmr         <= '0;
            cnt_r       <= '0;
            up_r        <= 1'b0;
            steps_left  <= '0;
            err_badcnt  <= 1'b0;
            err_timeout <= 1'b0;
            err_unlock  <= 1'b0;
        end else begin
            state <= state_nxt;
            // per-state dwell counter, restarts on every state change
            tmr   <= (state_nxt != state) ? '0 : tmr + TMR_W'(1);
            if (accept) begin
                cnt_r       <= req_cnt;
                up_r        <= req_up;
                steps_left  <= req_steps;
                err_badcnt  <= 1'b0;
                err_timeout <= 1'b0;
                err_unlock  <= 1'b0;
            end
            if (state == S_NEXT && lock) steps_left <= steps_dec;
            if (set_badcnt)  err_badcnt  <= 1'b1;
            if (set_timeout) err_timeout <= 1'b1;
            if (set_unlock)  err_unlock  <= 1'b1;
        end
    end

`ifdef FPLL_DPS_ACCUM_EN
    logic [NUM_COUNTERS-1:0][AW-1:0] accum;
    logic [AW-1:0]                   burst_ext;

    assign burst_ext   = AW'(burst);
    assign phase_accum = accum;

    always_ff @(posedge avmmclk) begin
        if (avmmrst) begin
            accum <= '0;
        end else if (state == S_NEXT && lock) begin
            for (int i = 0; i < NUM_COUNTERS; i++)
                if (cnt_r == 4'(i))
                    accum[i] <= up_r ? accum[i] + burst_ext : accum[i] - burst_ext;
        end
    end
`endif

endmodule

// File: tb/tb_twentynm_fpll_dps_ctrl.sv
// Directed self-checking bench for twentynm_fpll_dps_ctrl (TIMEOUT_CYCLES overridden to 16).
module tb_twentynm_fpll_dps_ctrl;
    logic        avmmclk = 1'b0;
    logic        avmmrst;
    logic        req_valid, req_ready;
    logic [3:0]  req_cnt;
    logic [15:0] req_steps;
    logic        req_up;
    logic        busy, done, err_badcnt, err_timeout, err_unlock;
    logic [15:0] steps_left;
    logic [3:0]  cnt_sel;
    logic [2:0]  num_phase_shifts;
    logic        up_dn, phase_en, phase_done, lock;
`ifdef FPLL_DPS_ACCUM_EN
    logic [4*17-1:0] phase_accum;
`endif

    int n_chk = 0;
    int n_err = 0;
    int done_cyc, pe_cnt, n_bursts;
    logic [2:0]  b_num [8];
    logic [3:0]  b_sel [8];
    logic        b_up  [8];
    logic [15:0] b_left[8];

    twentynm_fpll_dps_ctrl #(
        .NUM_COUNTERS(4), .STEP_W(16), .PHASE_EN_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
`ifdef FPLL_DPS_ACCUM_EN
        .phase_accum(phase_accum),
`endif
        .avmmclk(avmmclk), .avmmrst(avmmrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cnt(req_cnt),
        .req_steps(req_steps), .req_up(req_up),
        .busy(busy), .done(done),
        .err_badcnt(err_badcnt), .err_timeout(err_timeout), .err_unlock(err_unlock),
        .steps_left(steps_left), .cnt_sel(cnt_sel), .num_phase_shifts(num_phase_shifts),
        .up_dn(up_dn), .phase_en(phase_en), .phase_done(phase_done), .lock(lock)
    );

    always #5 avmmclk = ~avmmclk;

    task automatic tick;
        @(posedge avmmclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it cycle by cycle (cycle 0 = CHECK, right after the accept edge).
    // phase_done pulses d cycles after phase_en falls (d<0: never); lock drops at cycle drop_cyc.
    // Returns positioned in the done cycle.
    task automatic run_req(input logic [3:0] cnt, input logic [15:0] steps, input logic up,
                           input int d, input int drop_cyc);
        int  fall_cyc = -1;
        bit  prev_pe  = 0;
        bit  seen     = 0;
        n_bursts = 0; pe_cnt = 0; done_cyc = -1;
        req_cnt = cnt; req_steps = steps; req_up = up; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (c == drop_cyc) lock = 1'b0;
            if (phase_en) begin
                if (!prev_pe && n_bursts < 8) begin
                    b_num[n_bursts]  = num_phase_shifts;
                    b_sel[n_bursts]  = cnt_sel;
                    b_up[n_bursts]   = up_dn;
                    b_left[n_bursts] = steps_left;
                    n_bursts++;
                end
                pe_cnt++;
            end else if (prev_pe) begin
                fall_cyc = c;
            end
            prev_pe    = phase_en;
            phase_done = (d >= 0 && fall_cyc >= 0 && c == fall_cyc + d);
            if (done) begin
                done_cyc = c;
                seen     = 1;
            end else begin
                tick;
            end
        end
        phase_done = 1'b0;
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    initial begin
        avmmrst = 1'b1; lock = 1'b1; req_valid = 1'b0; req_cnt = '0; req_steps = '0;
        req_up = 1'b0; phase_done = 1'b0;
        tick; tick;
        chk("rst_ready",    32'(req_ready), 32'd1);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_phase_en", 32'(phase_en), 32'd0);
        chk("rst_steps",    32'(steps_left), 32'd0);
        chk("rst_dps",      32'({cnt_sel, num_phase_shifts, up_dn}), 32'd0);
        chk("rst_errs",     32'({err_badcnt, err_timeout, err_unlock}), 32'd0);
        lock = 1'b0; #1;
        chk("rst_ready_nolock", 32'(req_ready), 32'd0);
        lock = 1'b1;
        avmmrst = 1'b0;
        tick;

        // single burst: done at 4 + 2 + 3 = 9
        run_req(4'd2, 16'd5, 1'b1, 3, -1);
        chk("t1_done_cyc", done_cyc, 32'd9);
        chk("t1_pe_cnt",   pe_cnt, 32'd2);
        chk("t1_bursts",   n_bursts, 32'd1);
        chk("t1_num",      32'(b_num[0]), 32'd5);
        chk("t1_sel",      32'(b_sel[0]), 32'd2);
        chk("t1_updn",     32'(b_up[0]), 32'd1);
        chk("t1_errs",     32'({err_badcnt, err_timeout, err_unlock}), 32'd0);
        chk("t1_steps",    32'(steps_left), 32'd0);
        chk("t1_dps_fin",  32'({cnt_sel, num_phase_shifts, up_dn, phase_en}), 32'd0);
        tick;
        chk("t1_idle_done",  32'(done), 32'd0);
        chk("t1_idle_ready", 32'(req_ready), 32'd1);
        chk("t1_idle_busy",  32'(busy), 32'd0);

        // three bursts 7,7,6 down on counter 1
        run_req(4'd1, 16'd20, 1'b0, 1, -1);
        chk("t2_done_cyc", done_cyc, 32'd19);
        chk("t2_bursts",   n_bursts, 32'd3);
        chk("t2_nums",     32'({b_num[0], b_num[1], b_num[2]}), 32'({3'd7, 3'd7, 3'd6}));
        chk("t2_left0",    32'(b_left[0]), 32'd20);
        chk("t2_left1",    32'(b_left[1]), 32'd13);
        chk("t2_left2",    32'(b_left[2]), 32'd6);
        chk("t2_updn",     32'({b_up[0], b_up[1], b_up[2]}), 32'd0);
        chk("t2_pe_cnt",   pe_cnt, 32'd6);
        chk("t2_steps",    32'(steps_left), 32'd0);
        chk("t2_errs",     32'({err_badcnt, err_timeout, err_unlock}), 32'd0);
`ifdef FPLL_DPS_ACCUM_EN
        chk("t2_accum1",   32'(phase_accum[17 +: 17]), 32'h1ffec);
`endif
        tick;
        chk("t2_single_done", 32'(done), 32'd0);

        // out-of-range counter: rejected in CHECK
        run_req(4'd5, 16'd20, 1'b1, 0, -1);
        chk("t3_done_cyc", done_cyc, 32'd1);
        chk("t3_badcnt",   32'(err_badcnt), 32'd1);
        chk("t3_pe_cnt",   pe_cnt, 32'd0);
        chk("t3_steps",    32'(steps_left), 32'd20);
        tick;
        chk("t3_sticky",   32'(err_badcnt), 32'd1);

        // phase_done never returns: 16 WAIT cycles (4..19), FIN at 20
        run_req(4'd0, 16'd3, 1'b1, -1, -1);
        chk("t4_done_cyc", done_cyc, 32'd20);
        chk("t4_timeout",  32'(err_timeout), 32'd1);
        chk("t4_badcnt_clr", 32'(err_badcnt), 32'd0);
        chk("t4_steps",    32'(steps_left), 32'd3);
        tick;
        chk("t4_ready",    32'(req_ready), 32'd1);

        // lock lost in the first PULSE cycle of burst 2
        run_req(4'd3, 16'd20, 1'b1, 1, 8);
        chk("t5_done_cyc", done_cyc, 32'd9);
        chk("t5_phase_en", 32'(phase_en), 32'd0);
        chk("t5_pe_cnt",   pe_cnt, 32'd3);
        chk("t5_unlock",   32'(err_unlock), 32'd1);
        chk("t5_timeout_clr", 32'(err_timeout), 32'd0);
        chk("t5_steps",    32'(steps_left), 32'd13);
        tick; tick;
        chk("t5_ready_nolock", 32'(req_ready), 32'd0);
        lock = 1'b1; #1;
        chk("t5_ready_lock", 32'(req_ready), 32'd1);

        // reset mid-PULSE, then a clean request
        req_cnt = 4'd2; req_steps = 16'd5; req_up = 1'b1; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick; tick;
        chk("t6_in_pulse", 32'(phase_en), 32'd1);
        avmmrst = 1'b1;
        tick;
        chk("t6_rst_pe",    32'(phase_en), 32'd0);
        chk("t6_rst_outs",  32'({busy, done, cnt_sel, num_phase_shifts, up_dn}), 32'd0);
        chk("t6_rst_errs",  32'({err_badcnt, err_timeout, err_unlock}), 32'd0);
        chk("t6_rst_steps", 32'(steps_left), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        avmmrst = 1'b0;
        tick;
        run_req(4'd2, 16'd3, 1'b0, 0, -1);
        chk("t6_done_cyc", done_cyc, 32'd6);
        chk("t6_num",      32'(b_num[0]), 32'd3);
        chk("t6_updn",     32'(b_up[0]), 32'd0);
        chk("t6_errs",     32'({err_badcnt, err_timeout, err_unlock}), 32'd0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
